// File: rtl/instr_encoder.sv
// RV32I field encoder: packs decoded op/rd/rs1/rs2/imm into 32-b machine words and
// streams them to an imem write port at consecutive word addresses.
module instr_encoder #(
  parameter int AW    = 32,
  parameter int DEPTH = 1024
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic [AW-1:0]                i_base_addr,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [5:0]                   i_in_op,
  input  logic [4:0]                   i_in_rd,
  input  logic [4:0]                   i_in_rs1,
  input  logic [4:0]                   i_in_rs2,
  input  logic [31:0]                  i_in_imm,
  input  logic                         i_in_last,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [AW-1:0]                o_out_addr,
  output logic [31:0]                  o_out_instr,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int CW = $clog2(DEPTH+1);

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;

  localparam logic [2:0] F_NOP = 3'd0, F_R = 3'd1, F_I = 3'd2, F_SH = 3'd3,
                         F_S   = 3'd4, F_B = 3'd5, F_U = 3'd6, F_J  = 3'd7;

  localparam logic [6:0] OPC_IMM = 7'b0010011, OPC_R   = 7'b0110011, OPC_LD  = 7'b0000011,
                         OPC_ST  = 7'b0100011, OPC_LUI = 7'b0110111, OPC_AUI = 7'b0010111,
                         OPC_JAL = 7'b1101111, OPC_JR  = 7'b1100111, OPC_BR  = 7'b1100011;

  logic [1:0]    r_state;
  logic [AW-1:0] r_ptr;
  logic [CW-1:0] r_count, r_accepted;
  logic          r_last_taken, r_out_last, r_out_valid, r_err;
  logic [AW-1:0] r_out_addr;
  logic [31:0]   r_out_instr;

  logic [2:0]    w_fmt;
  logic [6:0]    w_opc, w_f7;
  logic [2:0]    w_f3;
  logic [31:0]   w_word;
  logic          w_illegal, w_accept, w_out_hs, w_cnt_full;
  logic [CW-1:0] w_count_nxt;

  // Op -> (format, opcode, funct3); funct7 only matters for SUB/SRA/SRAI.
  always_comb begin
    w_fmt = F_NOP; w_opc = OPC_IMM; w_f3 = 3'd0; w_f7 = 7'd0; w_illegal = 1'b0;
    case (i_in_op)
      6'd0 : {w_fmt, w_opc, w_f3} = {F_I,  OPC_IMM, 3'd0};
      6'd1 : {w_fmt, w_opc, w_f3} = {F_I,  OPC_IMM, 3'd2};
      6'd2 : {w_fmt, w_opc, w_f3} = {F_I,  OPC_IMM, 3'd3};
      6'd3 : {w_fmt, w_opc, w_f3} = {F_I,  OPC_IMM, 3'd4};
      6'd4 : {w_fmt, w_opc, w_f3} = {F_I,  OPC_IMM, 3'd6};
      6'd5 : {w_fmt, w_opc, w_f3} = {F_I,  OPC_IMM, 3'd7};
      6'd6 : {w_fmt, w_opc, w_f3} = {F_SH, OPC_IMM, 3'd1};
      6'd7 : {w_fmt, w_opc, w_f3, w_f7} = {F_SH, OPC_IMM, 3'd5, 7'b0100000};
      6'd8 : {w_fmt, w_opc, w_f3} = {F_SH, OPC_IMM, 3'd5};
      6'd9 : {w_fmt, w_opc, w_f3, w_f7} = {F_R, OPC_R, 3'd0, 7'b0100000};
      6'd10: {w_fmt, w_opc, w_f3} = {F_R,  OPC_R,   3'd0};
      6'd11: {w_fmt, w_opc, w_f3} = {F_R,  OPC_R,   3'd1};
      6'd12: {w_fmt, w_opc, w_f3} = {F_R,  OPC_R,   3'd2};
      6'd13: {w_fmt, w_opc, w_f3} = {F_R,  OPC_R,   3'd3};
      6'd14: {w_fmt, w_opc, w_f3} = {F_R,  OPC_R,   3'd4};
      6'd15: {w_fmt, w_opc, w_f3, w_f7} = {F_R, OPC_R, 3'd5, 7'b0100000};
      6'd16: {w_fmt, w_opc, w_f3} = {F_R,  OPC_R,   3'd5};
      6'd17: {w_fmt, w_opc, w_f3} = {F_R,  OPC_R,   3'd6};
      6'd18: {w_fmt, w_opc, w_f3} = {F_R,  OPC_R,   3'd7};
      6'd19: {w_fmt, w_opc, w_f3} = {F_I,  OPC_LD,  3'd0};
      6'd20: {w_fmt, w_opc, w_f3} = {F_I,  OPC_LD,  3'd1};
      6'd21: {w_fmt, w_opc, w_f3} = {F_I,  OPC_LD,  3'd2};
      6'd22: {w_fmt, w_opc, w_f3} = {F_I,  OPC_LD,  3'd4};
      6'd23: {w_fmt, w_opc, w_f3} = {F_I,  OPC_LD,  3'd5};
      6'd24: {w_fmt, w_opc, w_f3} = {F_S,  OPC_ST,  3'd0};
      6'd25: {w_fmt, w_opc, w_f3} = {F_S,  OPC_ST,  3'd1};
      6'd26: {w_fmt, w_opc, w_f3} = {F_S,  OPC_ST,  3'd2};
      6'd27: {w_fmt, w_opc} = {F_U, OPC_LUI};
      6'd28: {w_fmt, w_opc} = {F_U, OPC_AUI};
      6'd29: {w_fmt, w_opc} = {F_J, OPC_JAL};
      6'd30: {w_fmt, w_opc, w_f3} = {F_I,  OPC_JR,  3'd0};
      6'd31: {w_fmt, w_opc, w_f3} = {F_B,  OPC_BR,  3'd0};
      6'd32: {w_fmt, w_opc, w_f3} = {F_B,  OPC_BR,  3'd1};
      6'd33: {w_fmt, w_opc, w_f3} = {F_B,  OPC_BR,  3'd4};
      6'd34: {w_fmt, w_opc, w_f3} = {F_B,  OPC_BR,  3'd5};
      6'd35: {w_fmt, w_opc, w_f3} = {F_B,  OPC_BR,  3'd6};
      6'd36: {w_fmt, w_opc, w_f3} = {F_B,  OPC_BR,  3'd7};
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_word = 32'h0000_0013;
    case (w_fmt)
      F_R:  w_word = {w_f7, i_in_rs2, i_in_rs1, w_f3, i_in_rd, w_opc};
      F_I:  w_word = {i_in_imm[11:0], i_in_rs1, w_f3, i_in_rd, w_opc};
      F_SH: w_word = {w_f7, i_in_imm[4:0], i_in_rs1, w_f3, i_in_rd, w_opc};
      F_S:  w_word = {i_in_imm[11:5], i_in_rs2, i_in_rs1, w_f3, i_in_imm[4:0], w_opc};
      F_B:  w_word = {i_in_imm[12], i_in_imm[10:5], i_in_rs2, i_in_rs1, w_f3,
                      i_in_imm[4:1], i_in_imm[11], w_opc};
      F_U:  w_word = {i_in_imm[31:12], i_in_rd, w_opc};
      F_J:  w_word = {i_in_imm[20], i_in_imm[10:1], i_in_imm[11], i_in_imm[19:12],
                      i_in_rd, w_opc};
      default: w_word = 32'h0000_0013;
    endcase
  end

  assign o_in_ready  = (r_state == S_RUN) & (!r_out_valid | i_out_ready) & !r_last_taken
                     & (r_accepted < CW'(DEPTH));
  assign w_accept    = i_in_valid & o_in_ready;
  assign w_out_hs    = r_out_valid & i_out_ready;
  assign w_count_nxt = r_count + CW'(1);
  assign w_cnt_full  = (w_count_nxt == CW'(DEPTH));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_count      <= '0;
      r_accepted   <= '0;
      r_last_taken <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_addr   <= '0;
      r_out_instr  <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_state      <= S_RUN;
          r_ptr        <= i_base_addr & ~AW'(3);
          r_count      <= '0;
          r_accepted   <= '0;
          r_last_taken <= 1'b0;
          r_err        <= 1'b0;
        end
        S_RUN: begin
          // An accept reloads the output register even while the old word hands off.
          if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out_instr  <= w_word;
            r_out_addr   <= r_ptr;
            r_out_last   <= i_in_last;
            r_ptr        <= r_ptr + AW'(4);
            r_accepted   <= r_accepted + CW'(1);
            r_last_taken <= r_last_taken | i_in_last;
            if (w_illegal) r_err <= 1'b1;
          end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
          end
          if (w_out_hs) begin
            r_count <= w_count_nxt;
            if (r_out_last || w_cnt_full) r_state <= S_DONE;
            if (!r_out_last && w_cnt_full) r_err <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_addr  = r_out_addr;
  assign o_out_instr = r_out_instr;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_err       = r_err;
  assign o_count     = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded vectors, stall/throughput, burst end,
// illegal op, DEPTH overflow (second instance, DEPTH=4), async reset and op round-trip.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid, in_last, out_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;

  logic        in_ready, out_valid, busy, done, err;
  logic [31:0] out_addr, out_instr;
  logic [10:0] count;

  logic        in_ready_b, out_valid_b, busy_b, done_b, err_b;
  logic [31:0] out_addr_b, out_instr_b;
  logic [2:0]  count_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_encoder #(.AW(32), .DEPTH(1024)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_base_addr(base_addr),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_op(in_op), .i_in_rd(in_rd),
    .i_in_rs1(in_rs1), .i_in_rs2(in_rs2), .i_in_imm(in_imm), .i_in_last(in_last),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_addr(out_addr),
    .o_out_instr(out_instr), .o_busy(busy), .o_done(done), .o_err(err), .o_count(count)
  );

  instr_encoder #(.AW(32), .DEPTH(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_base_addr(base_addr),
    .i_in_valid(in_valid), .o_in_ready(in_ready_b), .i_in_op(in_op), .i_in_rd(in_rd),
    .i_in_rs1(in_rs1), .i_in_rs2(in_rs2), .i_in_imm(in_imm), .i_in_last(in_last),
    .o_out_valid(out_valid_b), .i_out_ready(out_ready), .o_out_addr(out_addr_b),
    .o_out_instr(out_instr_b), .o_busy(busy_b), .o_done(done_b), .o_err(err_b),
    .o_count(count_b)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [5:0] op, input logic [4:0] rd, rs1, rs2,
                      input logic [31:0] imm, input logic last);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_last = last;
  endtask

  // Independent decoder: opcode/funct3/funct7 back to op number (7'h7F = unknown).
  function automatic logic [6:0] dec_op(input logic [31:0] w);
    logic [2:0] f3 = w[14:12];
    logic       alt = w[30];
    logic [6:0] r = 7'h7F;
    case (w[6:0])
      7'b0010011: case (f3)
        3'd0: r = 0; 3'd2: r = 1; 3'd3: r = 2; 3'd4: r = 3; 3'd6: r = 4; 3'd7: r = 5;
        3'd1: r = 6; default: r = alt ? 7'd7 : 7'd8;
      endcase
      7'b0110011: case (f3)
        3'd0: r = alt ? 7'd9 : 7'd10; 3'd1: r = 11; 3'd2: r = 12; 3'd3: r = 13;
        3'd4: r = 14; 3'd5: r = alt ? 7'd15 : 7'd16; 3'd6: r = 17; default: r = 18;
      endcase
      7'b0000011: case (f3)
        3'd0: r = 19; 3'd1: r = 20; 3'd2: r = 21; 3'd4: r = 22; 3'd5: r = 23; default: r = 7'h7F;
      endcase
      7'b0100011: r = (f3 < 3) ? 7'(24 + f3) : 7'h7F;
      7'b0110111: r = 27;
      7'b0010111: r = 28;
      7'b1101111: r = 29;
      7'b1100111: r = 30;
      7'b1100011: case (f3)
        3'd0: r = 31; 3'd1: r = 32; 3'd4: r = 33; 3'd5: r = 34; 3'd6: r = 35; 3'd7: r = 36;
        default: r = 7'h7F;
      endcase
      default: r = 7'h7F;
    endcase
    return r;
  endfunction

  // Register fields that exist in the format implied by the opcode; others forced to 0.
  function automatic logic [14:0] regs(input logic [6:0] opc, input logic [4:0] rd, rs1, rs2);
    logic hrd  = !(opc == 7'b0100011 || opc == 7'b1100011);
    logic hrs1 = !(opc == 7'b0110111 || opc == 7'b0010111 || opc == 7'b1101111);
    logic hrs2 = (opc == 7'b0110011 || opc == 7'b0100011 || opc == 7'b1100011);
    return {hrd ? rd : 5'd0, hrs1 ? rs1 : 5'd0, hrs2 ? rs2 : 5'd0};
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    step(); step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy_done_err", 64'({busy, done, err}), 64'd0);
    chk("rst_addr_instr_count", {out_addr ^ out_instr, 21'd0, count}, 64'd0);
    rst_n = 1'b1;
    step();

    // Burst 1: four beats, output stalled three cycles after the first accept.
    start = 1'b1; base_addr = 32'h103;
    step();
    start = 1'b0;
    chk("b1_busy", 64'(busy), 64'd1);
    chk("b1_in_ready_idle_out", 64'(in_ready), 64'd1);
    beat(6'd0, 5'd1, 5'd0, 5'd4, 32'hFFFF_FFFF, 1'b0);
    step();
    chk("addi_instr", 64'(out_instr), 64'hFFF0_0093);
    chk("addi_addr", 64'(out_addr), 64'h100);
    chk("addi_valid", 64'(out_valid), 64'd1);
    beat(6'd26, 5'd9, 5'd1, 5'd2, 32'd8, 1'b0);
    for (int s = 0; s < 3; s++) begin
      step();
      chk("stall_instr", 64'(out_instr), 64'hFFF0_0093);
      chk("stall_addr", 64'(out_addr), 64'h100);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_count", 64'(count), 64'd0);
    end
    out_ready = 1'b1; #1;
    chk("unstall_in_ready", 64'(in_ready), 64'd1);
    step();
    chk("sw_instr", 64'(out_instr), 64'h0020_A423);
    chk("sw_addr", 64'(out_addr), 64'h104);
    chk("sw_count", 64'(count), 64'd1);
    beat(6'd9, 5'd3, 5'd1, 5'd2, 32'h1234_5678, 1'b0);
    step();
    chk("sub_instr", 64'(out_instr), 64'h4020_81B3);
    chk("sub_addr", 64'(out_addr), 64'h108);
    beat(6'd29, 5'd0, 5'd7, 5'd7, 32'hFFFF_FFFC, 1'b1);
    step();
    chk("jal_instr", 64'(out_instr), 64'hFFDF_F06F);
    chk("jal_addr", 64'(out_addr), 64'h10C);
    in_valid = 1'b0; in_last = 1'b0; #1;
    chk("after_last_in_ready", 64'(in_ready), 64'd0);
    chk("pre_done", 64'(done), 64'd0);
    step();
    chk("b1_done", 64'(done), 64'd1);
    chk("b1_count", 64'(count), 64'd4);
    chk("b1_out_valid_clr", 64'(out_valid), 64'd0);
    step();
    chk("b1_done_pulse_end", 64'(done), 64'd0);
    chk("b1_idle", 64'(busy), 64'd0);

    // Burst 2: illegal op, start pulse during RUN, branch as last beat.
    start = 1'b1; base_addr = 32'h200;
    step();
    start = 1'b0;
    beat(6'd40, 5'd1, 5'd2, 5'd3, 32'h55, 1'b0);
    step();
    chk("illegal_nop", 64'(out_instr), 64'h13);
    chk("illegal_addr", 64'(out_addr), 64'h200);
    chk("illegal_err", 64'(err), 64'd1);
    beat(6'd7, 5'd5, 5'd6, 5'd0, 32'd3, 1'b0);
    start = 1'b1; base_addr = 32'h500;
    step();
    start = 1'b0;
    chk("srai_instr", 64'(out_instr), 64'h4033_5293);
    chk("start_in_run_ignored", 64'(out_addr), 64'h204);
    beat(6'd31, 5'd7, 5'd1, 5'd2, 32'hFFFF_FFF8, 1'b1);
    step();
    chk("beq_instr", 64'(out_instr), 64'hFE20_8CE3);
    chk("beq_addr", 64'(out_addr), 64'h208);
    in_valid = 1'b0; in_last = 1'b0;
    step();
    chk("b2_done", 64'({done, count}), {53'd0, 1'b1, 11'd3});
    step();
    chk("b2_err_sticky", 64'({busy, err}), 64'b01);

    // Burst 3: round-trip every op through an independent decoder at full throughput.
    start = 1'b1; base_addr = 32'h0;
    step();
    start = 1'b0;
    chk("start_clears_err", 64'(err), 64'd0);
    for (int k = 0; k <= 36; k++) begin
      logic [4:0]  rd  = 5'((k * 7 + 1) & 31);
      logic [4:0]  rs1 = 5'((k * 5 + 3) & 31);
      logic [4:0]  rs2 = 5'((k * 3 + 2) & 31);
      logic [31:0] imm = $urandom;
      beat(6'(k), rd, rs1, rs2, imm, k == 36);
      #1;
      chk("rt_in_ready", 64'(in_ready), 64'd1);
      step();
      chk("rt_addr", 64'(out_addr), 64'(k * 4));
      chk("rt_fields", 64'({dec_op(out_instr),
                            regs(out_instr[6:0], out_instr[11:7], out_instr[19:15], out_instr[24:20])}),
                       64'({7'(k), regs(out_instr[6:0], rd, rs1, rs2)}));
    end
    in_valid = 1'b0; in_last = 1'b0;
    step();
    chk("rt_done", 64'({done, count}), {53'd0, 1'b1, 11'd37});
    step();

    // Burst 4: five beats without last; DEPTH=4 instance overflows.
    start = 1'b1; base_addr = 32'h0;
    step();
    start = 1'b0;
    chk("ovf_busy_b", 64'({busy_b, err_b}), 64'b10);
    beat(6'd0, 5'd1, 5'd1, 5'd0, 32'd1, 1'b0);
    for (int s = 0; s < 4; s++) step();
    chk("ovf_in_ready_b", 64'(in_ready_b), 64'd0);
    step();
    chk("ovf_done_b", 64'(done_b), 64'd1);
    chk("ovf_err_b", 64'(err_b), 64'd1);
    chk("ovf_count_b", 64'(count_b), 64'd4);
    chk("ovf_out_valid_b", 64'(out_valid_b), 64'd0);
    chk("a_mid_burst", 64'({out_valid, busy, count}), {51'd0, 2'b11, 11'd4});

    // Async reset while out_valid is high: outputs clear without a clock edge.
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_flags", 64'({in_ready, busy, done, err}), 64'd0);
    chk("arst_addr_instr", {out_addr, out_instr}, 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    step();
    chk("arst_no_done", 64'({done, done_b}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
